// File: rtl/network_link_pipeline.sv
// network_link_pipeline: credit-safe pipelined NoC link.
// Flits pass through PipelineStages forward registers into per-VC receive
// FIFOs. A round-robin arbiter drains the FIFOs toward the receiver. Per-VC go
// toward the sender is regenerated from buffered plus in-flight occupancy, so
// the link never over-issues credits.
// Optional: define NETWORK_LINK_PIPELINE_ERR_EN to add a sticky link_error_o
// flag, set on any illegal input flit.
module network_link_pipeline #(
    parameter int NetworkFlitWidth               = 64,
    parameter int NetworkFlitTypeWidth           = 2,
    parameter int NetworkBroadcastWidth          = 1,
    parameter int NetworkVirtualChannelIdWidth   = 1,
    parameter int NetworkNumberOfVirtualChannels = 2,
    parameter int PipelineStages                 = 2,
    parameter int BufferDepth                    = 4,
    localparam int DW = NetworkFlitWidth + NetworkFlitTypeWidth +
                        NetworkBroadcastWidth + NetworkVirtualChannelIdWidth
) (
    input  logic                                      clk_network_i,
    input  logic                                      rst_network_i,
    input  logic                                      network_valid_i,
    input  logic [DW-1:0]                             network_data_i,
    output logic [NetworkNumberOfVirtualChannels-1:0] network_go_o,
    output logic                                      network_valid_o,
    output logic [DW-1:0]                             network_data_o,
    input  logic [NetworkNumberOfVirtualChannels-1:0] network_go_i
`ifdef NETWORK_LINK_PIPELINE_ERR_EN
    ,
    output logic                                      link_error_o
`endif
);

    localparam int NumVC = NetworkNumberOfVirtualChannels;
    localparam int VCW   = NetworkVirtualChannelIdWidth;
    localparam int CW    = $clog2(BufferDepth + 1);
    localparam int PW    = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;
    localparam int RW    = (NumVC > 1) ? $clog2(NumVC) : 1;

    logic [VCW-1:0]            in_vc;
    logic [NumVC-1:0]          accept;
    logic                      illegal;

    logic [PipelineStages-1:0] pipe_valid;
    logic [DW-1:0]             pipe_data [PipelineStages];
    logic [VCW-1:0]            tail_vc;
    logic [NumVC-1:0]          deliver;

    logic [DW-1:0]             mem      [NumVC][BufferDepth];
    logic [PW-1:0]             wr_ptr   [NumVC];
    logic [PW-1:0]             rd_ptr   [NumVC];
    logic [CW-1:0]             count    [NumVC];
    logic [CW-1:0]             inflight [NumVC];
    logic [CW-1:0]             count_next    [NumVC];
    logic [CW-1:0]             inflight_next [NumVC];
    logic [NumVC-1:0]          go_next;

    logic [RW-1:0]             rr_ptr;
    logic [NumVC-1:0]          ready;
    logic [NumVC-1:0]          grant;
    logic                      grant_any;
    logic [RW-1:0]             grant_vc;
    logic [DW-1:0]             out_data;

    // Input legality: a flit is accepted only on an existing VC whose go is high
    always_comb begin
        in_vc  = network_data_i[DW-1 -: VCW];
        accept = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (network_valid_i && (32'(in_vc) == v) && network_go_o[v]) begin
                accept[v] = 1'b1;
            end
        end
        illegal = network_valid_i && (accept == '0);
    end

    // Decode which VC buffer the pipe tail writes this cycle
    always_comb begin
        tail_vc = pipe_data[PipelineStages-1][DW-1 -: VCW];
        deliver = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            deliver[v] = pipe_valid[PipelineStages-1] && (32'(tail_vc) == v);
        end
    end

    // Round-robin pick: first ready VC at or above rr_ptr, else first below it
    always_comb begin
        grant_any = 1'b0;
        grant_vc  = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            ready[v] = (count[v] != '0) && network_go_i[v];
        end
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (!grant_any && ready[v] && (v >= 32'(rr_ptr))) begin
                grant_any = 1'b1;
                grant_vc  = RW'(v);
            end
        end
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (!grant_any && ready[v] && (v < 32'(rr_ptr))) begin
                grant_any = 1'b1;
                grant_vc  = RW'(v);
            end
        end
        grant    = '0;
        out_data = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (grant_any && (32'(grant_vc) == v)) begin
                grant[v] = 1'b1;
                out_data = mem[v][rd_ptr[v]];
            end
        end
    end

    // Post-edge occupancy per VC; go reflects buffered plus in-flight flits
    always_comb begin
        for (int unsigned v = 0; v < NumVC; v++) begin
            count_next[v]    = count[v] + CW'(deliver[v]) - CW'(grant[v]);
            inflight_next[v] = inflight[v] + CW'(accept[v]) - CW'(deliver[v]);
            go_next[v]       = (32'(count_next[v]) + 32'(inflight_next[v])) < 32'(BufferDepth);
        end
    end

    // Forward pipe: stall-free shift register of {valid, data}
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            pipe_valid <= '0;
            for (int unsigned s = 0; s < PipelineStages; s++) begin
                pipe_data[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= |accept;
            if (|accept) begin
                pipe_data[0] <= network_data_i;
            end
            for (int unsigned s = 1; s < PipelineStages; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_data[s]  <= pipe_data[s-1];
            end
        end
    end

    // Buffer storage: written by the pipe tail, no reset needed
    always_ff @(posedge clk_network_i) begin
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (deliver[v]) begin
                mem[v][wr_ptr[v]] <= pipe_data[PipelineStages-1];
            end
        end
    end

    // Per-VC pointers, counts, in-flight tracking and registered go
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                wr_ptr[v]   <= '0;
                rd_ptr[v]   <= '0;
                count[v]    <= '0;
                inflight[v] <= '0;
            end
            network_go_o <= '0;
        end else begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                if (deliver[v]) begin
                    wr_ptr[v] <= (32'(wr_ptr[v]) == BufferDepth - 1) ? '0 : wr_ptr[v] + 1'b1;
                end
                if (grant[v]) begin
                    rd_ptr[v] <= (32'(rd_ptr[v]) == BufferDepth - 1) ? '0 : rd_ptr[v] + 1'b1;
                end
                count[v]    <= count_next[v];
                inflight[v] <= inflight_next[v];
            end
            network_go_o <= go_next;
        end
    end

    // Registered output stage and round-robin pointer
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            network_valid_o <= 1'b0;
            network_data_o  <= '0;
            rr_ptr          <= '0;
        end else begin
            network_valid_o <= grant_any;
            if (grant_any) begin
                network_data_o <= out_data;
                rr_ptr         <= (32'(grant_vc) == NumVC - 1) ? '0 : grant_vc + 1'b1;
            end
        end
    end

`ifdef NETWORK_LINK_PIPELINE_ERR_EN
    // Sticky protocol error flag
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            link_error_o <= 1'b0;
        end else if (illegal) begin
            link_error_o <= 1'b1;
        end
    end
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_network_link_pipeline.sv
// Self-checking bench for network_link_pipeline with a queue-based reference
// model: every accepted flit is outstanding until it leaves the link, so go is
// simply (outstanding < depth); a flit becomes eligible for output one edge
// after it reaches its buffer.
module tb_network_link_pipeline;

    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int NVC   = 2;
    localparam int DW    = 68;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [1:0]    go_out;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [1:0]    go_in;
`ifdef NETWORK_LINK_PIPELINE_ERR_EN
    logic          err;
`endif

    network_link_pipeline #(
        .NetworkFlitWidth(64),
        .NetworkFlitTypeWidth(2),
        .NetworkBroadcastWidth(1),
        .NetworkVirtualChannelIdWidth(1),
        .NetworkNumberOfVirtualChannels(NVC),
        .PipelineStages(N),
        .BufferDepth(DEPTH)
    ) dut (
        .clk_network_i(clk),
        .rst_network_i(rst),
        .network_valid_i(valid_in),
        .network_data_i(data_in),
        .network_go_o(go_out),
        .network_valid_o(valid_out),
        .network_data_o(data_out),
        .network_go_i(go_in)
`ifdef NETWORK_LINK_PIPELINE_ERR_EN
        ,
        .link_error_o(err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW-1:0] d;
        int            arr;
    } ent_t;

    ent_t          mq [NVC][$];
    logic [1:0]    m_go;
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_rr;
    logic          m_err;
    int            cyc;

    int n_pass  = 0;
    int n_total = 0;

    task automatic model_update();
        ent_t e;
        int   w;
        bit   found;
        int   vc;
        cyc++;
        if (rst) begin
            for (int v = 0; v < NVC; v++) mq[v].delete();
            m_go = '0; m_valid = 1'b0; m_data = '0; m_rr = 0; m_err = 1'b0;
            return;
        end
        found = 1'b0;
        w = 0;
        for (int i = 0; i < NVC; i++) begin
            int v;
            v = (m_rr + i) % NVC;
            if (!found && mq[v].size() > 0 && go_in[v]) begin
                if (mq[v][0].arr < cyc) begin
                    found = 1'b1;
                    w = v;
                end
            end
        end
        if (found) begin
            e = mq[w].pop_front();
            m_valid = 1'b1;
            m_data = e.d;
            m_rr = (w + 1) % NVC;
        end else begin
            m_valid = 1'b0;
        end
        if (valid_in) begin
            vc = int'(data_in[DW-1]);
            if (vc < NVC && m_go[vc]) begin
                e.d = data_in;
                e.arr = cyc + N;
                mq[vc].push_back(e);
            end else begin
                m_err = 1'b1;
            end
        end
        for (int v = 0; v < NVC; v++) m_go[v] = (mq[v].size() < DEPTH);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_flit(input logic vc);
        logic [DW-1:0] f;
        f = {vc, 1'($urandom), 2'($urandom), $urandom, $urandom};
        return f;
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; data_in = '0; go_in = 2'b11;
        tick();
        n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out); else n_pass++;
        n_total++; if (data_out !== '0) $display("FAIL reset_data: got %h expected 0", data_out); else n_pass++;
        n_total++; if (go_out !== 2'b00) $display("FAIL reset_go: got %b expected 00", go_out); else n_pass++;
`ifdef NETWORK_LINK_PIPELINE_ERR_EN
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
`endif
        rst = 1'b0;
        tick();
        n_total++; if (go_out !== 2'b11) $display("FAIL go_after_release: got %b expected 11", go_out); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++; if (valid_out !== 1'b0) $display("FAIL idle_valid: got %b expected 0", valid_out); else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] exp68;
        exp68 = {1'b0, 1'b0, 2'b00, 64'hDEAD_BEEF_0000_0001};
        go_in = 2'b11;
        valid_in = 1'b1; data_in = exp68;
        tick();
        valid_in = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_total++;
            if (valid_out !== (c == 3)) $display("FAIL single_latency c=%0d: got %b expected %b", c, valid_out, (c == 3));
            else n_pass++;
            if (c == 3) begin
                n_total++; if (data_out !== exp68) $display("FAIL single_data: got %h expected %h", data_out, exp68); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] sent [$];
        logic [DW-1:0] exp;
        int n_acc;
        n_acc = 0;
        go_in = 2'b01;
        for (int c = 0; c < 10; c++) begin
            if (go_out[1]) begin
                valid_in = 1'b1; data_in = rand_flit(1'b1);
                sent.push_back(data_in); n_acc++;
            end else begin
                valid_in = 1'b0;
            end
            tick();
            n_total++; if (go_out !== m_go) $display("FAIL bp_go: got %b expected %b", go_out, m_go); else n_pass++;
            n_total++; if (valid_out !== 1'b0) $display("FAIL bp_hold_valid: got %b expected 0", valid_out); else n_pass++;
        end
        valid_in = 1'b0;
        n_total++; if (n_acc !== 4) $display("FAIL bp_accepted: got %0d expected 4", n_acc); else n_pass++;
        n_total++; if (go_out[1] !== 1'b0) $display("FAIL bp_go1_low: got %b expected 0", go_out[1]); else n_pass++;
        go_in = 2'b11;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (valid_out === 1'b1) begin
                exp = (sent.size() > 0) ? sent.pop_front() : '0;
                n_total++; if (data_out !== exp) $display("FAIL bp_order: got %h expected %h", data_out, exp); else n_pass++;
            end
        end
        n_total++; if (sent.size() != 0) $display("FAIL bp_drained: got %0d left expected 0", sent.size()); else n_pass++;
        n_total++; if (go_out[1] !== 1'b1) $display("FAIL bp_go1_rise: got %b expected 1", go_out[1]); else n_pass++;
    endtask

    task automatic test_contention();
        logic prev_vc;
        go_in = 2'b00;
        for (int k = 0; k < 6; k++) begin
            valid_in = 1'b1; data_in = rand_flit(1'(k % 2));
            tick();
        end
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_total++; if (go_out !== 2'b11) $display("FAIL cont_go: got %b expected 11", go_out); else n_pass++;
        go_in = 2'b11;
        prev_vc = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_total++; if (valid_out !== 1'b1) $display("FAIL cont_valid k=%0d: got %b expected 1", k, valid_out); else n_pass++;
            n_total++; if (data_out !== m_data) $display("FAIL cont_data k=%0d: got %h expected %h", k, data_out, m_data); else n_pass++;
            n_total++; if (data_out[DW-1] === prev_vc) $display("FAIL cont_alternate k=%0d: got vc %b expected %b", k, data_out[DW-1], ~prev_vc); else n_pass++;
            prev_vc = data_out[DW-1];
        end
        tick();
        n_total++; if (valid_out !== 1'b0) $display("FAIL cont_end: got %b expected 0", valid_out); else n_pass++;
    endtask

    task automatic test_throughput();
        logic [DW-1:0] sent [$];
        logic [DW-1:0] exp;
        int outs, first, last;
        outs = 0; first = -1; last = -1;
        go_in = 2'b11;
        for (int c = 0; c < 110; c++) begin
            if (c < 100) begin
                n_total++; if (go_out[0] !== 1'b1) $display("FAIL tp_go0 c=%0d: got %b expected 1", c, go_out[0]); else n_pass++;
                valid_in = 1'b1; data_in = rand_flit(1'b0); sent.push_back(data_in);
            end else begin
                valid_in = 1'b0;
            end
            tick();
            if (valid_out === 1'b1) begin
                exp = (sent.size() > 0) ? sent.pop_front() : '0;
                n_total++; if (data_out !== exp) $display("FAIL tp_data: got %h expected %h", data_out, exp); else n_pass++;
                if (first < 0) first = c;
                last = c; outs++;
            end
        end
        n_total++; if (outs != 100) $display("FAIL tp_count: got %0d expected 100", outs); else n_pass++;
        n_total++; if (last - first != 99) $display("FAIL tp_consecutive: got span %0d expected 99", last - first); else n_pass++;
    endtask

    task automatic test_random();
        logic vc;
        for (int c = 0; c < 300; c++) begin
            go_in = 2'($urandom);
            vc = 1'($urandom);
            valid_in = ($urandom_range(3) != 0);
            if (valid_in && !m_go[vc] && $urandom_range(7) != 0) valid_in = 1'b0;
            data_in = rand_flit(vc);
            tick();
            n_total++; if (valid_out !== m_valid) $display("FAIL rnd_valid c=%0d: got %b expected %b", c, valid_out, m_valid); else n_pass++;
            if (m_valid) begin
                n_total++; if (data_out !== m_data) $display("FAIL rnd_data c=%0d: got %h expected %h", c, data_out, m_data); else n_pass++;
            end
            n_total++; if (go_out !== m_go) $display("FAIL rnd_go c=%0d: got %b expected %b", c, go_out, m_go); else n_pass++;
`ifdef NETWORK_LINK_PIPELINE_ERR_EN
            n_total++; if (err !== m_err) $display("FAIL rnd_err c=%0d: got %b expected %b", c, err, m_err); else n_pass++;
`endif
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        go_in = 2'b00;
        for (int c = 0; c < 5; c++) begin
            valid_in = 1'b1; data_in = rand_flit(1'(c % 2));
            tick();
        end
        go_in = 2'b11;
        tick();
        rst = 1'b1; valid_in = 1'b0;
        #1;
        n_total++; if (valid_out !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", valid_out); else n_pass++;
        n_total++; if (go_out !== 2'b00) $display("FAIL mid_rst_go: got %b expected 00", go_out); else n_pass++;
        n_total++; if (data_out !== '0) $display("FAIL mid_rst_data: got %h expected 0", data_out); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_total++; if (go_out !== 2'b11) $display("FAIL mid_go_release: got %b expected 11", go_out); else n_pass++;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_total++; if (valid_out !== 1'b0) $display("FAIL mid_discard c=%0d: got %b expected 0", c, valid_out); else n_pass++;
        end
    endtask

`ifdef NETWORK_LINK_PIPELINE_ERR_EN
    task automatic test_error();
        int outs;
        outs = 0;
        go_in = 2'b00;
        for (int c = 0; c < 4; c++) begin
            valid_in = 1'b1; data_in = rand_flit(1'b1);
            tick();
        end
        n_total++; if (go_out[1] !== 1'b0) $display("FAIL err_go1: got %b expected 0", go_out[1]); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL err_early: got %b expected 0", err); else n_pass++;
        data_in = rand_flit(1'b1);
        tick();
        valid_in = 1'b0;
        n_total++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else n_pass++;
        go_in = 2'b11;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (valid_out === 1'b1) outs++;
            n_total++; if (err !== 1'b1) $display("FAIL err_sticky c=%0d: got %b expected 1", c, err); else n_pass++;
        end
        n_total++; if (outs != 4) $display("FAIL err_dropped: got %0d flits expected 4", outs); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++; if (err !== 1'b0) $display("FAIL err_clear: got %b expected 0", err); else n_pass++;
        rst = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; go_in = '0;
        cyc = 0; m_go = '0; m_valid = 1'b0; m_data = '0; m_rr = 0; m_err = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_throughput();
        test_random();
        test_reset_mid();
`ifdef NETWORK_LINK_PIPELINE_ERR_EN
        test_error();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/network_link_pipeline.md
# network_link_pipeline

Parametrised, credit-safe pipelined tile-to-tile link for the 2D-mesh NoC. It is inserted on one directional router-to-router connection (valid/go/data triple) when tile spacing needs register stages. It carries flits through `PipelineStages` forward registers into per-VC receive buffers. It regenerates an exact per-VC `go_o` toward the sender, so long links never drop or duplicate flits.

## Interface
- `NetworkFlitWidth`, 64, flit payload bits
- `NetworkFlitTypeWidth`, 2, flit type bits
- `NetworkBroadcastWidth`, 1, broadcast bits
- `NetworkVirtualChannelIdWidth`, 1, VC id bits (≥1)
- `NetworkNumberOfVirtualChannels`, 2, VC count (≤ 2**VCIdWidth)
- `PipelineStages`, 2, forward register stages (1..8)
- `BufferDepth`, 4, flits per VC receive buffer (≥ PipelineStages+2 for full throughput; ≥2 legal)
- `DW` (local) = FlitWidth+FlitTypeWidth+BroadcastWidth+VCIdWidth; layout `{vc_id, broadcast, type, flit}`, vc_id at MSBs
- `clk_network_i  in  1  link clock`
- `rst_network_i  in  1  reset; one clock; reset is asynchronous and active-high`
- `network_valid_i  in  1  flit present from sender`
- `network_data_i  in  DW  flit from sender`
- `network_go_o  out  NumVC  per-VC permission to sender`
- `network_valid_o  out  1  flit toward receiving router`
- `network_data_o  out  DW  flit toward receiving router`
- `network_go_i  in  NumVC  per-VC permission from receiving router`
- `link_error_o  out  1  sticky protocol error (only with macro)`

## Operation
- Input acceptance: flit on VC v is legal in cycle t only if `network_go_o[v]`=1 in cycle t. A legal flit is captured into stage 1 at the edge and `inflight[v]` increments.
- Forward pipe: `PipelineStages` registers of {valid, data}, no stall. Stage N output is written into buffer[v] at the next edge and `inflight[v]` decrements.
- Buffers: per-VC circular FIFO, `BufferDepth` entries. Read/write pointers wrap modulo depth. Count is width clog2(BufferDepth+1).
- Go generation: `network_go_o[v]` is registered, equal to `(count_next[v] + inflight_next[v]) < BufferDepth`, using post-edge values. This makes it exact; no over-issue is possible.
- Output arbiter: round-robin over VCs with buffer non-empty and `network_go_i[v]`=1. The pointer advances past the winner. At most one flit per cycle. `network_valid_o`/`network_data_o` are registered; valid deasserts when there is no winner.
- Order preserved within a VC; interleaving across VCs allowed.
- Illegal input (valid with go_o[v]=0, or VC id ≥ NumVC): flit dropped, no state change.
- Simultaneous write and read on the same VC: count unchanged, both pointers advance.

## Timing
- Reset (async assert): all pipe valids 0, pointers/counts/inflight 0, arbiter pointer to VC 0. `network_valid_o`=0, `network_data_o`=0, `network_go_o`=0, `link_error_o`=0.
- First edge after reset release: `network_go_o` = all ones.
- Latency: flit accepted at edge t is written to buffer at edge t+PipelineStages. With go_i high and it winning arbitration, `network_valid_o` is high in the cycle after edge t+PipelineStages+1 (PipelineStages+1 cycles total).
- `network_go_o[v]` falls in the cycle after the edge that fills the last credit. It rises in the cycle after the edge that frees one.
- Reset mid-operation discards all buffered and in-flight flits. The sender must also be reset.

## Configuration
- `NETWORK_LINK_PIPELINE_ERR_EN` defined: `link_error_o` port present. It sets on any illegal input and stays set until reset.
- Undefined: port absent; illegal flits are silently dropped.

## Test plan
- Reset then idle: all outputs 0 during reset; `network_go_o`=2'b11 one edge after release; `network_valid_o` stays 0.
- Single flit VC0, payload 64'hDEAD_BEEF_0000_0001, go_i=11: valid_o high exactly 3 cycles after acceptance, identical 68-bit data.
- Back-pressure: go_i[1]=0, stream VC1 flits: go_o[1] drops after 4 accepted (2 in pipe + 2 buffered, count+inflight=4). Release go_i[1]: all 4 delivered in order, go_o[1] rises again.
- Two-VC contention: both buffers holding 3 flits, go_i=11: outputs alternate VC0,VC1,... over 6 consecutive cycles.
- Full throughput: 100 back-to-back VC0 flits, go_i=11: go_o[0] never drops; 100 flits out on consecutive cycles.
- With ERR_EN: drive valid on VC1 while go_o[1]=0: flit not delivered, link_error_o=1 next cycle and held until reset.
